conv2d_1_wr_arbiter: RTL and testbench
======================================

CONV2D_1_WR_ARBITER -- requirements
Module: conv2d_1_wr_arbiter

Interface
REQ-001 Parameter: DWIDTH, default 32, word width of every data port.
REQ-002 Parameter: LDEPTH, default 4, per-lane buffer depth in words (power of two, minimum 2).
REQ-003 Port: clock  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: req_wdata0..req_wdata7  in  DWIDTH each  result word from filter core 0..7.
REQ-006 Port: req_wrreq0..req_wrreq7  in  1 each  result valid from filter core 0..7, one word per high cycle.
REQ-007 Port: hold  out  1  throttle to the filter cores' input-FIFO read path.
REQ-008 Port: ff_wdata  out  DWIDTH  word to the shared output FIFO.
REQ-009 Port: ff_wrreq  out  1  write strobe to the shared output FIFO.
REQ-010 Port: ff_wtag  out  3  index of the lane that sourced ff_wdata.
REQ-011 Port: ff_full  in  1  output-FIFO almost-full; asserted with at least 1 free entry remaining.
REQ-012 Port: ovf_cnt  out  8  count of dropped words (see Configuration).

Function
REQ-013 Each lane SHALL own a LDEPTH-entry FIFO with a registered occupancy count (0..LDEPTH).
REQ-014 Push: req_wrreqN high at an edge SHALL write req_wdataN into lane N, unless the lane is full and not popped on that edge.
REQ-015 Push into a full lane on the same edge as a pop from that lane SHALL succeed with no drop; count stays LDEPTH.
REQ-016 Push into a full lane with no pop SHALL drop the word; lane contents are unchanged.
REQ-017 Grant: in each cycle with ff_full low and at least one lane non-empty, exactly one lane SHALL be popped.
REQ-018 Grant order SHALL be round-robin: search starts at (last granted index + 1) mod 8 and selects the first non-empty lane.
REQ-019 The last-granted pointer SHALL update only on a grant.
REQ-020 No grant SHALL occur while ff_full is high; lane contents and the pointer hold.
REQ-021 The popped word and lane index SHALL be registered into ff_wdata/ff_wtag, with ff_wrreq high for exactly the following cycle.
REQ-022 ff_wrreq SHALL be low in every cycle not following a grant; ff_wdata/ff_wtag hold their last value.
REQ-023 Latency: a word pushed at edge k into an empty lane with no competition SHALL appear with ff_wrreq high after edge k+2.
REQ-024 hold SHALL be high while any lane count >= LDEPTH-1, decoded from registered counts (no input-to-output combinational path).
REQ-025 Per-lane FIFO order SHALL be preserved; no word is duplicated or reordered within a lane.

Reset
REQ-026 Reset asserted SHALL immediately clear all lane counts and pointers, and set the grant pointer to 7, so lane 0 has first priority.
REQ-027 Reset SHALL drive ff_wrreq=0, ff_wdata=0, ff_wtag=0, hold=0 and ovf_cnt=0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered words; no write strobe is issued after reset deasserts until a new push.

Configuration
REQ-029 With macro CONV2D_ARB_OVF_CNT_EN defined, ovf_cnt SHALL increment by 1 per dropped word (REQ-016) and saturate at 255.
REQ-030 Simultaneous drops on multiple lanes in one cycle SHALL add the number of drops, saturating at 255.
REQ-031 Without CONV2D_ARB_OVF_CNT_EN, ovf_cnt SHALL be constant 0, no counter logic is instantiated, and drop behaviour is unchanged.

Verification
REQ-032 Single push: lane 3 writes 0x0000_00A5 at edge 1 with ff_full=0 -> ff_wrreq high after edge 3 only, ff_wdata=0x0000_00A5, ff_wtag=3.
REQ-033 Round-robin: lanes 0, 2 and 7 each push one word in the same cycle -> output tags 0, 2, 7 on consecutive cycles; then lane 0 pushes again -> tag 0.
REQ-034 Backpressure: 4 words are buffered in lane 1 and ff_full is held high 10 cycles -> no ff_wrreq during the stall and hold=1; on release, 4 writes in order on consecutive cycles.
REQ-035 Overflow (macro on): ff_full=1 and lane 5 receives 6 words -> first 4 are kept, ovf_cnt=2; with the macro off, ovf_cnt=0 and the same 4 words come out.
REQ-036 Full-lane push+pop: lane 2 is full, ff_full=0, and lane 2 is granted on the same edge as a push -> no drop, count stays 4.
REQ-037 Reset mid-stream: 3 lanes hold data and reset pulses for 1 cycle -> all outputs 0 immediately, and no ff_wrreq afterwards until a new req_wrreq.

Source files
------------

// File: rtl/conv2d_1_wr_arbiter.sv
// Eight-lane result-write arbiter: per-lane FIFOs, round-robin grant into one shared output FIFO.
// Optional dropped-word counter enabled by defining CONV2D_ARB_OVF_CNT_EN.
module conv2d_1_wr_arbiter #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned LDEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DWIDTH-1:0] req_wdata0,
    input  logic [DWIDTH-1:0] req_wdata1,
    input  logic [DWIDTH-1:0] req_wdata2,
    input  logic [DWIDTH-1:0] req_wdata3,
    input  logic [DWIDTH-1:0] req_wdata4,
    input  logic [DWIDTH-1:0] req_wdata5,
    input  logic [DWIDTH-1:0] req_wdata6,
    input  logic [DWIDTH-1:0] req_wdata7,
    input  logic              req_wrreq0,
    input  logic              req_wrreq1,
    input  logic              req_wrreq2,
    input  logic              req_wrreq3,
    input  logic              req_wrreq4,
    input  logic              req_wrreq5,
    input  logic              req_wrreq6,
    input  logic              req_wrreq7,
    output logic              hold,
    output logic [DWIDTH-1:0] ff_wdata,
    output logic              ff_wrreq,
    output logic [2:0]        ff_wtag,
    input  logic              ff_full,
    output logic [7:0]        ovf_cnt
);

    localparam int unsigned NL = 8;
    localparam int unsigned AW = $clog2(LDEPTH);
    localparam int unsigned CW = $clog2(LDEPTH + 1);

    logic [DWIDTH-1:0] req_data [NL];
    logic [NL-1:0]     req_valid;
    logic [NL-1:0]     stg_valid;
    logic [DWIDTH-1:0] stg_data [NL];
    logic [DWIDTH-1:0] mem [NL][LDEPTH];
    logic [AW-1:0]     rd_ptr [NL];
    logic [AW-1:0]     wr_ptr [NL];
    logic [CW-1:0]     cnt [NL];
    logic [CW-1:0]     cnt_nxt [NL];
    logic [NL-1:0]     pop;
    logic [NL-1:0]     push;
    logic [2:0]        last;
    logic [2:0]        gnt_idx;
    logic              gnt_valid;
    logic              hold_nxt;

    assign req_data[0] = req_wdata0;
    assign req_data[1] = req_wdata1;
    assign req_data[2] = req_wdata2;
    assign req_data[3] = req_wdata3;
    assign req_data[4] = req_wdata4;
    assign req_data[5] = req_wdata5;
    assign req_data[6] = req_wdata6;
    assign req_data[7] = req_wdata7;
    assign req_valid   = {req_wrreq7, req_wrreq6, req_wrreq5, req_wrreq4,
                          req_wrreq3, req_wrreq2, req_wrreq1, req_wrreq0};

    // Round-robin search starting just after the last granted lane
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = last;
        for (int i = 1; i <= NL; i++) begin
            if (!ff_full && !gnt_valid && cnt[3'(int'(last) + i)] != '0) begin
                gnt_valid = 1'b1;
                gnt_idx   = 3'(int'(last) + i);
            end
        end
    end

    // A staged word enters a full lane only when that lane is popped on the same edge
    always_comb begin
        pop      = '0;
        push     = '0;
        hold_nxt = 1'b0;
        for (int i = 0; i < NL; i++) begin
            pop[i]     = gnt_valid && (gnt_idx == 3'(i));
            push[i]    = stg_valid[i] && ((cnt[i] != CW'(LDEPTH)) || pop[i]);
            cnt_nxt[i] = cnt[i] + CW'(push[i]) - CW'(pop[i]);
            if (cnt_nxt[i] >= CW'(LDEPTH - 1)) begin
                hold_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stg_valid <= '0;
            last      <= 3'd7;
            ff_wrreq  <= 1'b0;
            ff_wdata  <= '0;
            ff_wtag   <= '0;
            hold      <= 1'b0;
            for (int i = 0; i < NL; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            stg_valid <= req_valid;
            hold      <= hold_nxt;
            ff_wrreq  <= gnt_valid;
            if (gnt_valid) begin
                last     <= gnt_idx;
                ff_wdata <= mem[gnt_idx][rd_ptr[gnt_idx]];
                ff_wtag  <= gnt_idx;
            end
            for (int i = 0; i < NL; i++) begin
                cnt[i] <= cnt_nxt[i];
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
            end
        end
    end

    // Data path needs no reset: occupancy counts gate every read
    always_ff @(posedge clock) begin
        for (int i = 0; i < NL; i++) begin
            stg_data[i] <= req_data[i];
            if (push[i]) mem[i][wr_ptr[i]] <= stg_data[i];
        end
    end

`ifdef CONV2D_ARB_OVF_CNT_EN
    logic [3:0] drop_num;
    logic [8:0] ovf_sum;
    logic [7:0] ovf_q;

    always_comb begin
        drop_num = '0;
        for (int i = 0; i < NL; i++) begin
            if (stg_valid[i] && !push[i]) drop_num = drop_num + 4'd1;
        end
        ovf_sum = 9'(ovf_q) + 9'(drop_num);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) ovf_q <= '0;
        else       ovf_q <= (ovf_sum > 9'd255) ? 8'd255 : ovf_sum[7:0];
    end

    assign ovf_cnt = ovf_q;
`else
    assign ovf_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_conv2d_1_wr_arbiter.sv
// Bench for conv2d_1_wr_arbiter: directed table, corner-case sequences and randomized traffic
// against a queue-based reference model.
module tb_conv2d_1_wr_arbiter;

    localparam int unsigned LDEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] wd [8];
    logic [7:0]  wr = '0;
    logic        ff_full = 1'b0;
    logic        hold, ff_wrreq;
    logic [31:0] ff_wdata;
    logic [2:0]  ff_wtag;
    logic [7:0]  ovf_cnt;

    int n_cmp = 0;
    int n_err = 0;

    conv2d_1_wr_arbiter #(.DWIDTH(32), .LDEPTH(LDEPTH)) dut (
        .clock(clock), .reset(reset),
        .req_wdata0(wd[0]), .req_wdata1(wd[1]), .req_wdata2(wd[2]), .req_wdata3(wd[3]),
        .req_wdata4(wd[4]), .req_wdata5(wd[5]), .req_wdata6(wd[6]), .req_wdata7(wd[7]),
        .req_wrreq0(wr[0]), .req_wrreq1(wr[1]), .req_wrreq2(wr[2]), .req_wrreq3(wr[3]),
        .req_wrreq4(wr[4]), .req_wrreq5(wr[5]), .req_wrreq6(wr[6]), .req_wrreq7(wr[7]),
        .hold(hold), .ff_wdata(ff_wdata), .ff_wrreq(ff_wrreq), .ff_wtag(ff_wtag),
        .ff_full(ff_full), .ovf_cnt(ovf_cnt)
    );

    always #5 clock = ~clock;

    // Reference model: lane queues, requests become visible to the arbiter one cycle later
    logic [31:0] mq [8][$];
    logic [7:0]  pend_v;
    logic [31:0] pend_d [8];
    int          last_m;
    logic        exp_v, exp_h;
    logic [31:0] exp_d;
    logic [2:0]  exp_t;
    int          exp_o;

    typedef struct {
        bit          rst;
        logic [7:0]  m;
        logic [31:0] dv;
        logic        ev;
        logic [2:0]  et;
        logic [31:0] ed;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            mq[i].delete();
            pend_d[i] = '0;
        end
        pend_v = '0;
        last_m = 7;
        exp_v  = 1'b0;
        exp_h  = 1'b0;
        exp_d  = '0;
        exp_t  = '0;
        exp_o  = 0;
    endtask

    task automatic check_all(input string nm);
        chk({nm, ".wrreq"}, 32'(ff_wrreq), 32'(exp_v));
        chk({nm, ".wdata"}, ff_wdata, exp_d);
        chk({nm, ".wtag"},  32'(ff_wtag), 32'(exp_t));
        chk({nm, ".hold"},  32'(hold), 32'(exp_h));
        chk({nm, ".ovf"},   32'(ovf_cnt), 32'(exp_o));
    endtask

    // One clock with the given request mask and full flag; wd must already be set
    task automatic cycle(input logic [7:0] m, input logic f);
        int g;
        int drops;
        wr      = m;
        ff_full = f;
        g       = -1;
        if (!f) begin
            for (int i = 1; i <= 8; i++) begin
                if (g < 0 && mq[(last_m + i) % 8].size() > 0) g = (last_m + i) % 8;
            end
        end
        exp_v = (g >= 0);
        if (g >= 0) begin
            exp_d  = mq[g].pop_front();
            exp_t  = 3'(g);
            last_m = g;
        end
        drops = 0;
        for (int i = 0; i < 8; i++) begin
            if (pend_v[i]) begin
                if (mq[i].size() < LDEPTH) mq[i].push_back(pend_d[i]);
                else drops++;
            end
        end
`ifdef CONV2D_ARB_OVF_CNT_EN
        exp_o = (exp_o + drops > 255) ? 255 : exp_o + drops;
`endif
        exp_h = 1'b0;
        for (int i = 0; i < 8; i++) if (mq[i].size() >= LDEPTH - 1) exp_h = 1'b1;
        pend_v = m;
        for (int i = 0; i < 8; i++) pend_d[i] = wd[i];
        @(posedge clock);
        #1;
        check_all("model");
    endtask

    // Asynchronous reset pulse raised mid-cycle; outputs must clear before any edge
    task automatic do_reset();
        wr      = '0;
        ff_full = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst.wrreq", 32'(ff_wrreq), 32'd0);
        chk("rst.wdata", ff_wdata, 32'd0);
        chk("rst.wtag",  32'(ff_wtag), 32'd0);
        chk("rst.hold",  32'(hold), 32'd0);
        chk("rst.ovf",   32'(ovf_cnt), 32'd0);
        model_clear();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_wd(input logic [31:0] dv);
        for (int i = 0; i < 8; i++) wd[i] = dv + 32'(i);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h08, 32'h0A2, 1'b0, 3'd0, 32'h0};
        tbl[1]  = '{1'b0, 8'h00, 32'h000, 1'b0, 3'd0, 32'h0};
        tbl[2]  = '{1'b0, 8'h00, 32'h000, 1'b1, 3'd3, 32'h0A5};
        tbl[3]  = '{1'b0, 8'h00, 32'h000, 1'b0, 3'd0, 32'h0};
        tbl[4]  = '{1'b1, 8'h85, 32'h100, 1'b0, 3'd0, 32'h0};
        tbl[5]  = '{1'b0, 8'h00, 32'h000, 1'b0, 3'd0, 32'h0};
        tbl[6]  = '{1'b0, 8'h00, 32'h000, 1'b1, 3'd0, 32'h100};
        tbl[7]  = '{1'b0, 8'h00, 32'h000, 1'b1, 3'd2, 32'h102};
        tbl[8]  = '{1'b0, 8'h00, 32'h000, 1'b1, 3'd7, 32'h107};
        tbl[9]  = '{1'b0, 8'h01, 32'h100, 1'b0, 3'd0, 32'h0};
        tbl[10] = '{1'b0, 8'h00, 32'h000, 1'b0, 3'd0, 32'h0};
        tbl[11] = '{1'b0, 8'h00, 32'h000, 1'b1, 3'd0, 32'h100};

        set_wd(32'h0);
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        check_all("por");
        reset = 1'b0;

        // Single push latency and round-robin order from reset
        for (int k = 0; k < 12; k++) begin
            if (tbl[k].rst) do_reset();
            set_wd(tbl[k].dv);
            cycle(tbl[k].m, 1'b0);
            chk("tbl.wrreq", 32'(ff_wrreq), 32'(tbl[k].ev));
            if (tbl[k].ev) begin
                chk("tbl.wtag",  32'(ff_wtag), 32'(tbl[k].et));
                chk("tbl.wdata", ff_wdata, tbl[k].ed);
            end
        end

        // Backpressure: four words in lane 1, ten stalled cycles, then in-order drain
        do_reset();
        for (int k = 0; k < 10; k++) begin
            set_wd(32'h1FF + 32'(k));
            cycle((k < 4) ? 8'h02 : 8'h00, 1'b1);
            chk("stall.wrreq", 32'(ff_wrreq), 32'd0);
        end
        chk("stall.hold", 32'(hold), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cycle(8'h00, 1'b0);
            chk("drain.wrreq", 32'(ff_wrreq), 32'd1);
            chk("drain.wtag",  32'(ff_wtag), 32'd1);
            chk("drain.wdata", ff_wdata, 32'h200 + 32'(k));
        end
        cycle(8'h00, 1'b0);
        chk("drain.idle", 32'(ff_wrreq), 32'd0);

        // Overflow: six words into lane 5 while stalled, last two dropped
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_wd(32'h4FB + 32'(k));
            cycle((k < 6) ? 8'h20 : 8'h00, 1'b1);
        end
`ifdef CONV2D_ARB_OVF_CNT_EN
        chk("ovf.cnt", 32'(ovf_cnt), 32'd2);
`else
        chk("ovf.cnt", 32'(ovf_cnt), 32'd0);
`endif
        for (int k = 0; k < 4; k++) begin
            cycle(8'h00, 1'b0);
            chk("ovf.wtag",  32'(ff_wtag), 32'd5);
            chk("ovf.wdata", ff_wdata, 32'h500 + 32'(k));
        end
        cycle(8'h00, 1'b0);
        chk("ovf.idle", 32'(ff_wrreq), 32'd0);

        // Full lane 2 pushed on the same edge it is popped: nothing dropped
        do_reset();
        for (int k = 0; k < 6; k++) begin
            set_wd(32'h3FE + 32'(k));
            cycle((k == 4) ? 8'h00 : 8'h04, 1'b1);
        end
        set_wd(32'h0);
        cycle(8'h00, 1'b0);
        chk("pp.wrreq", 32'(ff_wrreq), 32'd1);
        chk("pp.wdata", ff_wdata, 32'h400);
        chk("pp.hold",  32'(hold), 32'd1);
        chk("pp.ovf",   32'(ovf_cnt), 32'd0);
        for (int k = 1; k < 5; k++) begin
            cycle(8'h00, 1'b0);
            chk("pp.wdata", ff_wdata, 32'h400 + 32'(k < 4 ? k : 5));
        end

        // Reset in the middle of buffered traffic on lanes 0, 3, 6
        do_reset();
        set_wd(32'h300);
        cycle(8'h49, 1'b1);
        cycle(8'h49, 1'b1);
        cycle(8'h00, 1'b0);
        chk("mid.wdata", ff_wdata, 32'h300);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cycle(8'h00, 1'b0);
            chk("mid.quiet", 32'(ff_wrreq), 32'd0);
        end
        set_wd(32'h600);
        cycle(8'h08, 1'b0);
        cycle(8'h00, 1'b0);
        cycle(8'h00, 1'b0);
        chk("mid.new", 32'(ff_wrreq), 32'd1);
        chk("mid.tag", 32'(ff_wtag), 32'd3);

        // Randomized traffic: alternating dense and sparse phases, occasional resets
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] m;
            if (n % 700 == 699) do_reset();
            for (int i = 0; i < 8; i++) wd[i] = $urandom;
            if ((n / 250) % 2 == 0) m = 8'($urandom);
            else m = 8'($urandom & $urandom & $urandom);
            cycle(m, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
